axi_slave_mem: RTL and testbench

- AXI3 responder (slave) backed by an internal word-addressed memory. It is the other end of the master-side AXI interface the testbench driver uses.
- It terminates all five channels with independent write and read state machines, one outstanding transaction per direction.
- It serves as the DUT-side memory model and the reusable slave endpoint for driver/monitor bring-up.

---
 rtl/axi_slave_mem.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem.sv
// AXI3 slave endpoint backed by a word-addressed memory; independent write and read FSMs,
// one outstanding transaction per direction. Ready/valid and response outputs are registered.
//
//   state  | meaning
//   W_IDLE | AWREADY high, waiting for a write address
//   W_DATA | WREADY high, accepting beats until the beat count reaches AWLEN
//   W_RESP | BVALID high, holding BID/BRESP until BREADY
//   R_IDLE | ARREADY high, waiting for a read address
//   R_DATA | RVALID high, presenting beats until the RLAST handshake
module axi_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ID_WIDTH-1:0]   AWID,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic [3:0]            AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic [1:0]            AWBURST,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [ID_WIDTH-1:0]   WID,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic [3:0]            WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [ID_WIDTH-1:0]   BID,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [ID_WIDTH-1:0]   ARID,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [3:0]            ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic [1:0]            ARBURST,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [ID_WIDTH-1:0]   RID,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA} rstate_t;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> 2) < ADDR_WIDTH'(MEM_WORDS));
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    function automatic logic illegal_burst(input logic [3:0] len, input logic [2:0] size,
                                           input logic [1:0] burst);
        return (burst == 2'b11) || (size > 3'd2) ||
               ((burst == 2'b10) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
    endfunction

    // WRAP keeps the upper bits of the container base and wraps the offset inside it.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [3:0] len,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] incr, mask, nxt;
        incr = ADDR_WIDTH'(1) << size;
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        nxt  = a + incr;
        case (burst)
            2'b00:   nxt = a;
            2'b10:   nxt = (a & ~mask) | (nxt & mask);
            default: ;
        endcase
        return nxt;
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    wstate_t               wst_q, wst_d;
    logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [ID_WIDTH-1:0]   wtag_q, wtag_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [3:0]            wlen_q, wlen_d, wbeat_q, wbeat_d;
    logic [2:0]            wsize_q, wsize_d;
    logic [1:0]            wburst_q, wburst_d;
    logic                  wbad_q, wbad_d, werr_q, werr_d;
    logic                  mem_we, beat_err;

    rstate_t               rst_q, rst_d;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [ID_WIDTH-1:0]   rtag_q, rtag_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, rsel_addr;
    logic [3:0]            rlen_q, rlen_d, rbeat_q, rbeat_d;
    logic [2:0]            rsize_q, rsize_d;
    logic [1:0]            rburst_q, rburst_d;
    logic                  rbad_q, rbad_d, rsel_bad, rload, rsel_ok;

    always_comb begin
        wst_d     = wst_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wtag_d    = wtag_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wbeat_d   = wbeat_q;
        wsize_d   = wsize_q;
        wburst_d  = wburst_q;
        wbad_d    = wbad_q;
        werr_d    = werr_q;
        mem_we    = 1'b0;
        beat_err  = 1'b0;
        case (wst_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (AWVALID && awready_q) begin
                    wtag_d    = AWID;
                    waddr_d   = AWADDR;
                    wlen_d    = AWLEN;
                    wsize_d   = AWSIZE;
                    wburst_d  = AWBURST;
                    wbeat_d   = 4'd0;
                    wbad_d    = illegal_burst(AWLEN, AWSIZE, AWBURST);
                    werr_d    = wbad_d;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    wst_d     = W_DATA;
                end
            end
            W_DATA: begin
                if (WVALID && wready_q) begin
                    beat_err = !in_range(waddr_q) || (WID != wtag_q) ||
                               (WLAST != (wbeat_q == wlen_q));
                    mem_we   = !wbad_q && in_range(waddr_q);
                    werr_d   = werr_q | beat_err;
                    waddr_d  = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
                    wbeat_d  = wbeat_q + 4'd1;
                    if (wbeat_q == wlen_q) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bresp_d  = werr_d ? 2'b10 : 2'b00;
                        wst_d    = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (BREADY && bvalid_q) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wst_d     = W_IDLE;
                end
            end
            default: wst_d = W_IDLE;
        endcase
    end

    always_comb begin
        rst_d     = rst_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        rtag_d    = rtag_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rbeat_d   = rbeat_q;
        rsize_d   = rsize_q;
        rburst_d  = rburst_q;
        rbad_d    = rbad_q;
        rload     = 1'b0;
        rsel_addr = raddr_q;
        rsel_bad  = rbad_q;
        rsel_ok   = 1'b0;
        case (rst_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ARVALID && arready_q) begin
                    rtag_d    = ARID;
                    raddr_d   = ARADDR;
                    rlen_d    = ARLEN;
                    rsize_d   = ARSIZE;
                    rburst_d  = ARBURST;
                    rbeat_d   = 4'd0;
                    rbad_d    = illegal_burst(ARLEN, ARSIZE, ARBURST);
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rlast_d   = (ARLEN == 4'd0);
                    rload     = 1'b1;
                    rsel_addr = ARADDR;
                    rsel_bad  = rbad_d;
                    rst_d     = R_DATA;
                end
            end
            R_DATA: begin
                if (RREADY && rvalid_q) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        rst_d     = R_IDLE;
                    end else begin
                        raddr_d   = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
                        rbeat_d   = rbeat_q + 4'd1;
                        rlast_d   = (rbeat_d == rlen_q);
                        rload     = 1'b1;
                        rsel_addr = raddr_d;
                    end
                end
            end
            default: rst_d = R_IDLE;
        endcase
        // Beat data is captured from memory as it stands before the presenting edge.
        if (rload) begin
            rsel_ok = !rsel_bad && in_range(rsel_addr);
            rdata_d = rsel_ok ? mem_q[word_idx(rsel_addr)] : '0;
            rresp_d = rsel_ok ? 2'b00 : 2'b10;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wst_q     <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            wtag_q    <= '0;
            waddr_q   <= '0;
            wlen_q    <= 4'd0;
            wbeat_q   <= 4'd0;
            wsize_q   <= 3'd0;
            wburst_q  <= 2'b00;
            wbad_q    <= 1'b0;
            werr_q    <= 1'b0;
            rst_q     <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            rtag_q    <= '0;
            raddr_q   <= '0;
            rlen_q    <= 4'd0;
            rbeat_q   <= 4'd0;
            rsize_q   <= 3'd0;
            rburst_q  <= 2'b00;
            rbad_q    <= 1'b0;
        end else begin
            wst_q     <= wst_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            wtag_q    <= wtag_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wbeat_q   <= wbeat_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wbad_q    <= wbad_d;
            werr_q    <= werr_d;
            rst_q     <= rst_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            rtag_q    <= rtag_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rbeat_q   <= rbeat_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rbad_q    <= rbad_d;
        end
    end

    // Memory has no reset so its contents survive ARESETn.
    always_ff @(posedge ACLK) begin
        if (ARESETn && mem_we) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (WSTRB[b]) mem_q[word_idx(waddr_q)][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BID     = wtag_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RID     = rtag_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RLAST   = rlast_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: acts as the AXI master, one task per scenario,
// expected values written out by hand from the intended memory behaviour.
module tb_axi_slave_mem;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [3:0]  AWID, WID, BID, ARID, RID;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [3:0]  AWLEN, ARLEN, WSTRB;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

    always #5 ACLK = ~ACLK;

    axi_slave_mem dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] wbuf [16];
    logic [31:0] rbuf [16];
    logic [1:0]  rresp_v [16];
    int          rgap [16];
    logic [15:0] rlast_v;
    logic [15:0] wr_after;
    logic [3:0]  rid_v, b_id;
    logic [1:0]  b_resp;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic timeout(input string what);
        n_vec++;
        n_err++;
        $display("FAIL timeout waiting for %s", what);
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        n = 0;
        while (AWREADY !== 1'b1 && n < 50) begin tick(); n++; end
        if (n >= 50) timeout("AWREADY");
        tick();
        AWVALID = 1'b0;
    endtask

    task automatic w_send(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb,
                          input logic last);
        int n;
        WID = id; WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
        n = 0;
        while (WREADY !== 1'b1 && n < 50) begin tick(); n++; end
        if (n >= 50) timeout("WREADY");
        tick();
        WVALID = 1'b0;
        WLAST  = 1'b0;
    endtask

    task automatic b_get();
        int n;
        BREADY = 1'b1;
        n = 0;
        while (BVALID !== 1'b1 && n < 50) begin tick(); n++; end
        if (n >= 50) timeout("BVALID");
        b_id   = BID;
        b_resp = BRESP;
        tick();
        BREADY = 1'b0;
    endtask

    task automatic wr_burst(input logic [3:0] awid, input logic [3:0] wid, input logic [31:0] addr,
                            input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst,
                            input logic [3:0] strb, input int last_at);
        aw_send(awid, addr, len, size, burst);
        wr_after = '0;
        for (int i = 0; i <= int'(len); i++) begin
            w_send(wid, wbuf[i], strb, i == last_at);
            wr_after[i] = WREADY;
        end
        b_get();
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n;
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        n = 0;
        while (ARREADY !== 1'b1 && n < 50) begin tick(); n++; end
        if (n >= 50) timeout("ARREADY");
        tick();
        ARVALID = 1'b0;
    endtask

    task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int n;
        ar_send(id, addr, len, size, burst);
        RREADY  = 1'b1;
        rlast_v = '0;
        for (int i = 0; i <= int'(len); i++) begin
            n = 0;
            while (RVALID !== 1'b1 && n < 50) begin tick(); n++; end
            if (n >= 50) timeout("RVALID");
            rgap[i]    = n;
            rbuf[i]    = RDATA;
            rresp_v[i] = RRESP;
            rlast_v[i] = RLAST;
            rid_v      = RID;
            tick();
        end
        RREADY = 1'b0;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0; WLAST = 0;
        AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0;
        WID = 0; WDATA = 0; WSTRB = 0; ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0;
        repeat (3) tick();
        n_vec++;
        if ({AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST} !== 6'b0 || BRESP !== 2'b00 ||
            RRESP !== 2'b00 || RDATA !== 32'h0 || BID !== 4'h0 || RID !== 4'h0) begin
            n_err++;
            $display("FAIL reset_outputs: aw=%b w=%b b=%b ar=%b r=%b last=%b rdata=%h, want all 0",
                     AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, RDATA);
        end
        ARESETn = 1'b1;
        tick();
        n_vec++;
        if (AWREADY !== 1'b1 || ARREADY !== 1'b1 || WREADY !== 1'b0 || BVALID !== 1'b0 ||
            RVALID !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: awready=%b arready=%b wready=%b bvalid=%b rvalid=%b, want 1 1 0 0 0",
                     AWREADY, ARREADY, WREADY, BVALID, RVALID);
        end
    endtask

    task automatic test_single();
        wbuf[0] = 32'hDEADBEEF;
        wr_burst(4'h3, 4'h3, 32'h40, 4'd0, 3'd2, 2'b01, 4'hF, 0);
        n_vec++;
        if (b_id !== 4'h3 || b_resp !== 2'b00) begin
            n_err++;
            $display("FAIL single_b: got id=%h resp=%b, want id=3 resp=00", b_id, b_resp);
        end
        rd_burst(4'h5, 32'h40, 4'd0, 3'd2, 2'b01);
        n_vec++;
        if (rbuf[0] !== 32'hDEADBEEF || rresp_v[0] !== 2'b00 || rlast_v[0] !== 1'b1 || rid_v !== 4'h5) begin
            n_err++;
            $display("FAIL single_r: got data=%h resp=%b last=%b id=%h, want deadbeef 00 1 5",
                     rbuf[0], rresp_v[0], rlast_v[0], rid_v);
        end
    endtask

    task automatic test_incr();
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        wr_burst(4'h1, 4'h1, 32'h10, 4'd3, 3'd2, 2'b01, 4'hF, 3);
        n_vec++;
        if (b_resp !== 2'b00 || b_id !== 4'h1) begin
            n_err++;
            $display("FAIL incr_b: got id=%h resp=%b, want 1 00", b_id, b_resp);
        end
        rd_burst(4'h2, 32'h10, 4'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (rbuf[i] !== 32'(i + 1) || rresp_v[i] !== 2'b00 || (i > 0 && rgap[i] != 0)) begin
                n_err++;
                $display("FAIL incr_r%0d: got data=%h resp=%b gap=%0d, want %h 00 0",
                         i, rbuf[i], rresp_v[i], rgap[i], i + 1);
            end
        end
        n_vec++;
        if (rlast_v[3:0] !== 4'b1000) begin
            n_err++;
            $display("FAIL incr_rlast: got %b, want 1000", rlast_v[3:0]);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_incr [4];
        logic [31:0] exp_wrap [4];
        exp_incr = '{32'hB, 32'hC, 32'hD, 32'hA};
        exp_wrap = '{32'hA, 32'hB, 32'hC, 32'hD};
        wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD;
        wr_burst(4'h4, 4'h4, 32'h1C, 4'd3, 3'd2, 2'b10, 4'hF, 3);
        n_vec++;
        if (b_resp !== 2'b00) begin
            n_err++;
            $display("FAIL wrap_b: got resp=%b, want 00", b_resp);
        end
        rd_burst(4'h4, 32'h10, 4'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (rbuf[i] !== exp_incr[i]) begin
                n_err++;
                $display("FAIL wrap_incr_r%0d: got %h, want %h", i, rbuf[i], exp_incr[i]);
            end
        end
        rd_burst(4'h4, 32'h1C, 4'd3, 3'd2, 2'b10);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (rbuf[i] !== exp_wrap[i] || rresp_v[i] !== 2'b00) begin
                n_err++;
                $display("FAIL wrap_wrap_r%0d: got %h resp=%b, want %h 00", i, rbuf[i], rresp_v[i], exp_wrap[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic stable;
        aw_send(4'h7, 32'h80, 4'd0, 3'd2, 2'b01);
        w_send(4'h7, 32'hCAFEF00D, 4'hF, 1'b1);
        n_vec++;
        if (BVALID !== 1'b1) begin
            n_err++;
            $display("FAIL bp_latency: bvalid=%b right after last beat, want 1", BVALID);
        end
        BREADY = 1'b0;
        stable = 1'b1;
        repeat (5) begin
            tick();
            if (BVALID !== 1'b1 || BID !== 4'h7 || BRESP !== 2'b00 || AWREADY !== 1'b0) stable = 1'b0;
        end
        n_vec++;
        if (stable !== 1'b1) begin
            n_err++;
            $display("FAIL bp_hold: got bvalid=%b bid=%h bresp=%b awready=%b, want 1 7 00 0",
                     BVALID, BID, BRESP, AWREADY);
        end
        b_get();
        n_vec++;
        if (BVALID !== 1'b0 || AWREADY !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: bvalid=%b awready=%b, want 0 1", BVALID, AWREADY);
        end
        wbuf[0] = 32'hFFFFFFFF;
        wr_burst(4'h0, 4'h0, 32'h84, 4'd0, 3'd2, 2'b01, 4'hF, 0);
        wbuf[0] = 32'h12345678;
        wr_burst(4'h0, 4'h0, 32'h84, 4'd0, 3'd2, 2'b01, 4'b0011, 0);
        rd_burst(4'h0, 32'h84, 4'd0, 3'd2, 2'b01);
        n_vec++;
        if (rbuf[0] !== 32'hFFFF5678) begin
            n_err++;
            $display("FAIL strobe: got %h, want ffff5678", rbuf[0]);
        end
    endtask

    task automatic test_errors();
        wbuf[0] = 32'h11111111;
        wr_burst(4'h1, 4'h1, 32'h0, 4'd0, 3'd2, 2'b01, 4'hF, 0);
        wbuf[0] = 32'h22222222;
        wr_burst(4'h1, 4'h1, 32'h1000, 4'd0, 3'd2, 2'b01, 4'hF, 0);
        n_vec++;
        if (b_resp !== 2'b10) begin
            n_err++;
            $display("FAIL oor_write_b: got %b, want 10", b_resp);
        end
        rd_burst(4'h1, 32'h0, 4'd0, 3'd2, 2'b01);
        n_vec++;
        if (rbuf[0] !== 32'h11111111) begin
            n_err++;
            $display("FAIL oor_write_mem: word0 got %h, want 11111111", rbuf[0]);
        end
        rd_burst(4'h1, 32'h1000, 4'd0, 3'd2, 2'b01);
        n_vec++;
        if (rresp_v[0] !== 2'b10 || rbuf[0] !== 32'h0) begin
            n_err++;
            $display("FAIL oor_read: got resp=%b data=%h, want 10 0", rresp_v[0], rbuf[0]);
        end

        wbuf[0] = 32'h77;
        wr_burst(4'h2, 4'h2, 32'h20, 4'd0, 3'd2, 2'b01, 4'hF, 0);
        wbuf[0] = 32'h55;
        wr_burst(4'h2, 4'h2, 32'h20, 4'd0, 3'd2, 2'b11, 4'hF, 0);
        n_vec++;
        if (b_resp !== 2'b10) begin
            n_err++;
            $display("FAIL illegal_write_b: got %b, want 10", b_resp);
        end
        rd_burst(4'h2, 32'h20, 4'd0, 3'd2, 2'b01);
        n_vec++;
        if (rbuf[0] !== 32'h77) begin
            n_err++;
            $display("FAIL illegal_write_mem: got %h, want 77", rbuf[0]);
        end
        rd_burst(4'h2, 32'h20, 4'd0, 3'd2, 2'b11);
        n_vec++;
        if (rresp_v[0] !== 2'b10 || rbuf[0] !== 32'h0 || rlast_v[0] !== 1'b1) begin
            n_err++;
            $display("FAIL illegal_read_burst: got resp=%b data=%h last=%b, want 10 0 1",
                     rresp_v[0], rbuf[0], rlast_v[0]);
        end
        rd_burst(4'h2, 32'h20, 4'd0, 3'd3, 2'b01);
        n_vec++;
        if (rresp_v[0] !== 2'b10 || rbuf[0] !== 32'h0) begin
            n_err++;
            $display("FAIL illegal_read_size: got resp=%b data=%h, want 10 0", rresp_v[0], rbuf[0]);
        end
        rd_burst(4'h2, 32'h10, 4'd2, 3'd2, 2'b10);
        n_vec++;
        if (rresp_v[0] !== 2'b10 || rresp_v[1] !== 2'b10 || rresp_v[2] !== 2'b10 ||
            rbuf[1] !== 32'h0 || rlast_v[2:0] !== 3'b100) begin
            n_err++;
            $display("FAIL illegal_wrap_len: got resp=%b,%b,%b last=%b, want 10,10,10 100",
                     rresp_v[0], rresp_v[1], rresp_v[2], rlast_v[2:0]);
        end

        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 5);
        wr_burst(4'h2, 4'h2, 32'h30, 4'd3, 3'd2, 2'b01, 4'hF, 1);
        n_vec++;
        if (wr_after[3:0] !== 4'b0111 || b_resp !== 2'b10) begin
            n_err++;
            $display("FAIL early_wlast: wready after beats=%b resp=%b, want 0111 10", wr_after[3:0], b_resp);
        end
        wbuf[0] = 32'h99;
        wr_burst(4'h2, 4'h3, 32'h34, 4'd0, 3'd2, 2'b01, 4'hF, 0);
        n_vec++;
        if (b_resp !== 2'b10 || b_id !== 4'h2) begin
            n_err++;
            $display("FAIL wid_mismatch: got id=%h resp=%b, want 2 10", b_id, b_resp);
        end

        wbuf[0] = 32'h9; wbuf[1] = 32'hA0;
        wr_burst(4'h5, 4'h5, 32'hFFC, 4'd1, 3'd2, 2'b01, 4'hF, 1);
        n_vec++;
        if (b_resp !== 2'b10) begin
            n_err++;
            $display("FAIL partial_oor_b: got %b, want 10", b_resp);
        end
        rd_burst(4'h5, 32'hFFC, 4'd1, 3'd2, 2'b01);
        n_vec++;
        if (rbuf[0] !== 32'h9 || rresp_v[0] !== 2'b00 || rbuf[1] !== 32'h0 || rresp_v[1] !== 2'b10) begin
            n_err++;
            $display("FAIL partial_oor_r: got %h/%b %h/%b, want 9/00 0/10",
                     rbuf[0], rresp_v[0], rbuf[1], rresp_v[1]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp [4];
        exp = '{32'hB, 32'hC, 32'hD, 32'hA};
        ar_send(4'h6, 32'h10, 4'd7, 3'd2, 2'b01);
        RREADY = 1'b1;
        tick();
        tick();
        ARESETn = 1'b0;
        tick();
        n_vec++;
        if (RVALID !== 1'b0 || ARREADY !== 1'b0 || RLAST !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_assert: rvalid=%b arready=%b rlast=%b, want 0 0 0", RVALID, ARREADY, RLAST);
        end
        ARESETn = 1'b1;
        tick();
        n_vec++;
        if (ARREADY !== 1'b1 || RVALID !== 1'b0 || AWREADY !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_release: arready=%b rvalid=%b awready=%b, want 1 0 1", ARREADY, RVALID, AWREADY);
        end
        tick();
        n_vec++;
        if (RVALID !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_nobeats: rvalid=%b, want 0", RVALID);
        end
        RREADY = 1'b0;
        rd_burst(4'h6, 32'h10, 4'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (rbuf[i] !== exp[i]) begin
                n_err++;
                $display("FAIL midreset_mem%0d: got %h, want %h", i, rbuf[i], exp[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_incr();
        test_wrap();
        test_backpressure();
        test_errors();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
